// File: rtl/enc_ssi_pkg.sv
// Shared types and constants for the SSI absolute-encoder master.
package enc_ssi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_RECOVER = 2'd2
  } ssi_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

endpackage

// File: rtl/enc_ssi_master_if.sv
// Request/encoder-line/result bundle of the SSI master; clk and rst_n stay plain ports.
interface enc_ssi_master_if #(
  parameter int FRAME_BITS = 24,
  parameter int DATA_W     = 19
);
  logic                  start;
  logic                  miso;
  logic                  sck;
  logic                  cs_n;
  logic                  busy;
  logic [FRAME_BITS-1:0] frame;
  logic [DATA_W-1:0]     data;
  logic                  data_valid;
  logic                  err_ready;
  logic                  err_parity;

  modport master (
    input  start, miso,
    output sck, cs_n, busy, frame, data, data_valid, err_ready, err_parity
  );

  modport slave (
    output start, miso,
    input  sck, cs_n, busy, frame, data, data_valid, err_ready, err_parity
  );
endinterface

// File: rtl/enc_sck_gen.sv
// SCK divider: registered sck level with rise/fall strobes valid in the cycle before the edge.
module enc_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int              CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick_s;

  assign tick_s = (cnt_q == CNT_LAST);
  assign rise_o = tick_s & ~sck_q;
  assign fall_o = tick_s & sck_q;
  assign sck_o  = sck_q;

  // Half-period counter; load starts a low phase, disable parks sck high.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (load_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b1;
    end else if (tick_s) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
endmodule

// File: rtl/enc_ssi_master.sv
// SSI absolute-encoder master: clocks one frame per accepted start, extracts and
// optionally Gray-decodes the position field, checks optional even parity.
module enc_ssi_master #(
  parameter int FRAME_BITS  = 24,
  parameter int DATA_MSB    = 21,
  parameter int DATA_LSB    = 3,
  parameter int CLK_DIV     = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int GRAY        = 0,
  parameter int PARITY_EN   = 0
) (
  input logic              clk,
  input logic              rst_n,
  enc_ssi_master_if.master bus
);
  import enc_ssi_pkg::*;

  localparam int            DATA_W   = DATA_MSB - DATA_LSB + 1;
  localparam int            BW       = $clog2(FRAME_BITS);
  localparam int            RW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [RW-1:0] REC_LAST = RW'(TIMEOUT_CYC - 1);

  if (DATA_MSB >= FRAME_BITS || DATA_LSB > DATA_MSB || CLK_DIV < 2 ||
      FRAME_BITS < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("enc_ssi_master: illegal parameter combination");
  end

  ssi_state_e            state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [RW-1:0]         rec_q, rec_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_q, frame_d;
  logic [DATA_W-1:0]     data_q, data_d, field_s, conv_s;
  logic                  busy_q, cs_n_q, dv_q, dv_d, erdy_q, erdy_d, epar_q, epar_d;
  logic                  accept_s, done_s, sck_en_s, rise_s, fall_s, sck_s, par_ok_s;

  assign accept_s = (state_q == ST_IDLE) && bus.start && bus.miso;
  assign done_s   = (state_q == ST_SHIFT) && fall_s && (bit_q == BIT_LAST);
  // The last bit's falling strobe is suppressed so sck stays high into RECOVER.
  assign sck_en_s = (state_q == ST_SHIFT) && !done_s;
  assign par_ok_s = (PARITY_EN != PARITY_EVEN) || ((^shift_q) == 1'b0);

  enc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept_s),
    .en_i   (sck_en_s),
    .sck_o  (sck_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Position field extraction with optional Gray-to-binary prefix XOR from the MSB.
  always_comb begin
    field_s = shift_q[DATA_MSB:DATA_LSB];
    conv_s  = field_s;
    if (GRAY != 0) begin
      for (int i = DATA_W - 2; i >= 0; i--) begin
        conv_s[i] = conv_s[i+1] ^ field_s[i];
      end
    end else begin
      conv_s = field_s;
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rec_d   = rec_q;
    shift_d = shift_q;
    frame_d = frame_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    erdy_d  = 1'b0;
    epar_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
        end else if (bus.start) begin
          erdy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rise_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], bus.miso};
        end else begin
          shift_d = shift_q;
        end
        if (done_s) begin
          state_d = ST_RECOVER;
          rec_d   = '0;
          if (par_ok_s) begin
            frame_d = shift_q;
            data_d  = conv_s;
            dv_d    = 1'b1;
          end else begin
            epar_d = 1'b1;
          end
        end else if (fall_s) begin
          bit_d = bit_q + BW'(1);
        end else begin
          bit_d = bit_q;
        end
      end
      ST_RECOVER: begin
        if (rec_q == REC_LAST) begin
          state_d = ST_IDLE;
          rec_d   = '0;
        end else begin
          rec_d = rec_q + RW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      rec_q   <= '0;
      shift_q <= '0;
      frame_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dv_q    <= 1'b0;
      erdy_q  <= 1'b0;
      epar_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rec_q   <= rec_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      busy_q  <= (state_d != ST_IDLE);
      cs_n_q  <= (state_d != ST_SHIFT);
      dv_q    <= dv_d;
      erdy_q  <= erdy_d;
      epar_q  <= epar_d;
    end
  end

  assign bus.sck        = sck_s;
  assign bus.cs_n       = cs_n_q;
  assign bus.busy       = busy_q;
  assign bus.frame      = frame_q;
  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.err_ready  = erdy_q;
  assign bus.err_parity = epar_q;
endmodule

// File: tb/tb_enc_ssi_master.sv
// Scoreboard bench for enc_ssi_master: three instances (plain, Gray, parity) share
// clock and reset, each fed by its own behavioural SSI encoder.
module tb_enc_ssi_master;
  localparam int FB  = 24;
  localparam int DM  = 21;
  localparam int DL  = 3;
  localparam int DW  = DM - DL + 1;
  localparam int CD  = 4;
  localparam int TO  = 64;
  localparam int LAT = 1 + 2 * CD * FB;

  typedef struct {
    int           unit;
    logic         err;
    logic [FB-1:0] frame;
    logic [DW-1:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [FB-1:0] tx_frame[3];
  logic          idle_lvl[3];
  int            idx[3];
  logic          prev_sck[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enc_ssi_master_if #(.FRAME_BITS(FB), .DATA_W(DW)) if_a ();
  enc_ssi_master_if #(.FRAME_BITS(FB), .DATA_W(DW)) if_g ();
  enc_ssi_master_if #(.FRAME_BITS(FB), .DATA_W(DW)) if_p ();

  enc_ssi_master #(.FRAME_BITS(FB), .DATA_MSB(DM), .DATA_LSB(DL), .CLK_DIV(CD),
                   .TIMEOUT_CYC(TO), .GRAY(0), .PARITY_EN(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
  enc_ssi_master #(.FRAME_BITS(FB), .DATA_MSB(DM), .DATA_LSB(DL), .CLK_DIV(CD),
                   .TIMEOUT_CYC(TO), .GRAY(1), .PARITY_EN(0))
    dut_g (.clk(clk), .rst_n(rst_n), .bus(if_g.master));
  enc_ssi_master #(.FRAME_BITS(FB), .DATA_MSB(DM), .DATA_LSB(DL), .CLK_DIV(CD),
                   .TIMEOUT_CYC(TO), .GRAY(0), .PARITY_EN(1))
    dut_p (.clk(clk), .rst_n(rst_n), .bus(if_p.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [FB-1:0] f, input bit gray);
    logic [DW-1:0] fld;
    logic [DW-1:0] d;
    fld = f[DM:DL];
    for (int n = 0; n < DW; n++) d[n] = gray ? ^(fld >> n) : fld[n];
    return d;
  endfunction

  // Encoder: presents the next bit MSB-first after each falling sck while selected.
  task automatic enc_step(input logic sck, input logic cs_n, input logic idle,
                          input logic [FB-1:0] f, inout int i, inout logic p, inout logic m);
    if (cs_n) begin
      m = idle;
      i = 0;
    end else if (p && !sck && i < FB) begin
      m = f[FB-1-i];
      i = i + 1;
    end
    p = sck;
  endtask

  always @(negedge clk) begin
    enc_step(if_a.sck, if_a.cs_n, idle_lvl[0], tx_frame[0], idx[0], prev_sck[0], if_a.miso);
    enc_step(if_g.sck, if_g.cs_n, idle_lvl[1], tx_frame[1], idx[1], prev_sck[1], if_g.miso);
    enc_step(if_p.sck, if_p.cs_n, idle_lvl[2], tx_frame[2], idx[2], prev_sck[2], if_p.miso);
  end

  task automatic mon(input int u, input logic dv, input logic ep,
                     input logic [FB-1:0] fr, input logic [DW-1:0] d);
    exp_t e;
    if (dv || ep) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("unit", 32'(u), 32'(e.unit));
        chk("err_parity", 32'(ep), 32'(e.err));
        chk("data_valid", 32'(dv), 32'(!e.err));
        chk("frame", 32'(fr), 32'(e.frame));
        chk("data", 32'(d), 32'(e.data));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if_a.data_valid, if_a.err_parity, if_a.frame, if_a.data);
      mon(1, if_g.data_valid, if_g.err_parity, if_g.frame, if_g.data);
      mon(2, if_p.data_valid, if_p.err_parity, if_p.frame, if_p.data);
    end
  end

  task automatic set_start(input int u, input logic v);
    case (u)
      0:       if_a.start = v;
      1:       if_g.start = v;
      default: if_p.start = v;
    endcase
  endtask

  task automatic wait_until(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic request(input int u, input logic [FB-1:0] f, input logic push, input logic err,
                         input logic [FB-1:0] fr_exp, input logic [DW-1:0] d_exp, output int n);
    tx_frame[u] = f;
    @(posedge clk); #1;
    n = cyc;
    if (push) sb.push_back('{unit: u, err: err, frame: fr_exp, data: d_exp, due: cyc + LAT});
    set_start(u, 1'b1);
    @(posedge clk); #1;
    set_start(u, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [FB-1:0] f;
    for (int i = 0; i < 3; i++) begin
      tx_frame[i] = '0;
      idle_lvl[i] = 1'b1;
      idx[i] = 0;
      prev_sck[i] = 1'b1;
    end
    if_a.start = 1'b0;
    if_g.start = 1'b0;
    if_p.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(if_a.sck), 32'd1);
    chk("rst_cs_n", 32'(if_a.cs_n), 32'd1);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_frame", 32'(if_a.frame), 32'd0);
    chk("rst_data", 32'(if_a.data), 32'd0);
    chk("rst_pulses", 32'({if_a.data_valid, if_a.err_ready, if_a.err_parity}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame with a second start issued mid-shift that must be ignored.
    request(0, 24'h5A5A5A, 1'b1, 1'b0, 24'h5A5A5A, 19'h34B4B, n);
    wait_until(n + 1);
    chk("shift_cs_n", 32'(if_a.cs_n), 32'd0);
    chk("shift_sck_low", 32'(if_a.sck), 32'd0);
    chk("shift_busy", 32'(if_a.busy), 32'd1);
    wait_until(n + 1 + CD);
    chk("shift_sck_high", 32'(if_a.sck), 32'd1);
    wait_until(n + 50);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    wait_until(n + LAT);
    chk("done_cs_n", 32'(if_a.cs_n), 32'd1);
    chk("done_sck", 32'(if_a.sck), 32'd1);
    wait_until(n + LAT + TO - 1);
    chk("recover_busy", 32'(if_a.busy), 32'd1);
    wait_until(n + LAT + TO);
    chk("idle_busy", 32'(if_a.busy), 32'd0);
    chk("one_frame_only", 32'(sb.size()), 32'd0);

    // Gray decoding: the spec pattern plus a wider field.
    request(1, 24'h000018, 1'b1, 1'b0, 24'h000018, 19'h00002, n);
    wait_until(n + LAT + TO);
    request(1, 24'h5A5A5A, 1'b1, 1'b0, 24'h5A5A5A, exp_data(24'h5A5A5A, 1'b1), n);
    wait_until(n + LAT + TO);

    // Parity: good, bad (outputs hold), good zero frame.
    request(2, 24'h5A5A5A, 1'b1, 1'b0, 24'h5A5A5A, 19'h34B4B, n);
    wait_until(n + LAT + TO);
    request(2, 24'h000001, 1'b1, 1'b1, 24'h5A5A5A, 19'h34B4B, n);
    wait_until(n + LAT + TO);
    request(2, 24'h000000, 1'b1, 1'b0, 24'h000000, 19'h00000, n);
    wait_until(n + LAT + TO);

    // Encoder not ready: start rejected.
    idle_lvl[0] = 1'b0;
    @(negedge clk);
    request(0, 24'h000000, 1'b0, 1'b0, 24'h0, 19'h0, n);
    wait_until(n + 1);
    chk("err_ready_pulse", 32'(if_a.err_ready), 32'd1);
    chk("err_ready_busy", 32'(if_a.busy), 32'd0);
    chk("err_ready_sck", 32'(if_a.sck), 32'd1);
    wait_until(n + 2);
    chk("err_ready_once", 32'(if_a.err_ready), 32'd0);
    chk("err_ready_idle", 32'(if_a.busy), 32'd0);
    idle_lvl[0] = 1'b1;
    @(negedge clk);

    // Reset asserted during bit 10 aborts the frame asynchronously.
    request(0, 24'hC3A5F0, 1'b0, 1'b0, 24'h0, 19'h0, n);
    wait_until(n + 1 + 2 * CD * 10 + 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sck", 32'(if_a.sck), 32'd1);
    chk("abort_cs_n", 32'(if_a.cs_n), 32'd1);
    chk("abort_busy", 32'(if_a.busy), 32'd0);
    chk("abort_dv", 32'(if_a.data_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f = 24'hA5C3F0;
    request(0, f, 1'b1, 1'b0, f, exp_data(f, 1'b0), n);
    wait_until(n + LAT + TO);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
